dsp_mac_pipe: RTL and testbench



---
 rtl/dsp_mac_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Purpose: parametrised multiply-accumulate pipeline, P <= (A*B | 0) + Z, where Z is 0, C, P or P>>SHIFT.
// Latency: ABREG+MREG+1 enabled clocks from the inputs to P_o/valid_o. This is 3 with the default parameters.
// Backpressure: no ready handshake. ce_i=0 freezes every stage, and valid_o is masked while ce_i is low.
//
// Ports:
//   clock_i, reset_n_i    rising-edge clock and synchronous active-low reset
//   ce_i                  pipeline enable; 0 holds every stage register
//   valid_i, mode_i       operand qualifier; mode bit2 zeroes the product, bits[1:0] pick Z
//   A_i, B_i              unsigned multiplier operands
//   CREG_en_i, C_i        addend and its load enable (the C register loads even while ce_i=0)
//   P_o, valid_o          registered result and its new-result strobe
//
// Parameter ranges: ABREG 0..2, MREG 0..1, CREG 0..1, 1 <= SHIFT < P_WIDTH.
module dsp_mac_pipe #(
  parameter int A_WIDTH = 17,
  parameter int B_WIDTH = 17,
  parameter int C_WIDTH = 34,
  parameter int P_WIDTH = 34,
  parameter int SHIFT   = 17,
  parameter int ABREG   = 1,
  parameter int MREG    = 1,
  parameter int CREG    = 1
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               ce_i,
  input  logic               valid_i,
  input  logic [2:0]         mode_i,
  input  logic [A_WIDTH-1:0] A_i,
  input  logic [B_WIDTH-1:0] B_i,
  input  logic               CREG_en_i,
  input  logic [C_WIDTH-1:0] C_i,
  output logic [P_WIDTH-1:0] P_o,
  output logic               valid_o
);

  localparam int MW  = A_WIDTH + B_WIDTH;  // full product width
  localparam int ABW = MW + 3 + 1;         // {valid, mode, A, B}
  localparam int MSW = MW + 2 + 1;         // {valid, zsel, M}

  // ---------------------------------------------------------------------------
  // Input stages: A, B, mode and valid travel together as one vector.
  // ---------------------------------------------------------------------------
  logic [ABW-1:0] ab_in;
  logic [ABW-1:0] ab_out;

  assign ab_in = {valid_i, mode_i, A_i, B_i};

  generate
    if (ABREG == 0) begin : g_ab_bypass
      assign ab_out = ab_in;
    end else begin : g_ab_reg
      logic [ABW-1:0] ab_q [ABREG];
      logic [ABW-1:0] ab_d [ABREG];

      always_comb begin
        ab_d[0] = ce_i ? ab_in : ab_q[0];
        for (int i = 1; i < ABREG; i++) begin
          ab_d[i] = ce_i ? ab_q[i-1] : ab_q[i];
        end
      end

      always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
          for (int i = 0; i < ABREG; i++) ab_q[i] <= '0;
        end else begin
          for (int i = 0; i < ABREG; i++) ab_q[i] <= ab_d[i];
        end
      end

      assign ab_out = ab_q[ABREG-1];
    end
  endgenerate

  logic [A_WIDTH-1:0] a_s;
  logic [B_WIDTH-1:0] b_s;
  logic [2:0]         mode_ab;
  logic               vld_ab;

  assign b_s     = ab_out[0 +: B_WIDTH];
  assign a_s     = ab_out[B_WIDTH +: A_WIDTH];
  assign mode_ab = ab_out[MW +: 3];
  assign vld_ab  = ab_out[MW + 3];

  // ---------------------------------------------------------------------------
  // Multiplier: full-width unsigned product. Mode bit2 zeroes the product, which
  // turns the P stage into a pure add or shift of Z.
  // ---------------------------------------------------------------------------
  logic [MW-1:0] m_raw;

  assign m_raw = mode_ab[2] ? '0
               : ({{B_WIDTH{1'b0}}, a_s} * {{A_WIDTH{1'b0}}, b_s});

  // M stage. Only the Z select is still needed downstream, so mode bit2 is dropped here.
  logic [MSW-1:0] m_in;
  logic [MSW-1:0] m_out;

  assign m_in = {vld_ab, mode_ab[1:0], m_raw};

  generate
    if (MREG == 0) begin : g_m_bypass
      assign m_out = m_in;
    end else begin : g_m_reg
      logic [MSW-1:0] m_q;
      logic [MSW-1:0] m_d;

      always_comb begin
        m_d = ce_i ? m_in : m_q;
      end

      always_ff @(posedge clock_i) begin
        if (!reset_n_i) m_q <= '0;
        else            m_q <= m_d;
      end

      assign m_out = m_q;
    end
  endgenerate

  logic [MW-1:0] m_s;
  logic [1:0]    zsel_s;
  logic          vld_s;

  assign m_s    = m_out[0 +: MW];
  assign zsel_s = m_out[MW +: 2];
  assign vld_s  = m_out[MW + 2];

  // Align the product to P_WIDTH. A wider product is truncated, because all arithmetic is mod 2^P_WIDTH.
  logic [P_WIDTH-1:0] m_p;

  generate
    if (MW >= P_WIDTH) begin : g_m_trunc
      assign m_p = m_s[P_WIDTH-1:0];
      if (MW > P_WIDTH) begin : g_m_drop
        logic [MW-P_WIDTH-1:0] unused_m_hi;
        assign unused_m_hi = m_s[MW-1:P_WIDTH];
      end
    end else begin : g_m_ext
      assign m_p = {{(P_WIDTH-MW){1'b0}}, m_s};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // C path. The register loads on CREG_en_i alone, so a stall does not block it.
  // ---------------------------------------------------------------------------
  logic [C_WIDTH-1:0] c_src;

  generate
    if (CREG == 0) begin : g_c_bypass
      logic unused_c_en;
      assign unused_c_en = CREG_en_i;
      assign c_src       = C_i;
    end else begin : g_c_reg
      logic [C_WIDTH-1:0] c_q;
      logic [C_WIDTH-1:0] c_d;

      always_comb begin
        c_d = CREG_en_i ? C_i : c_q;
      end

      always_ff @(posedge clock_i) begin
        if (!reset_n_i) c_q <= '0;
        else            c_q <= c_d;
      end

      assign c_src = c_q;
    end
  endgenerate

  logic [P_WIDTH-1:0] c_p;

  generate
    if (C_WIDTH >= P_WIDTH) begin : g_c_trunc
      assign c_p = c_src[P_WIDTH-1:0];
      if (C_WIDTH > P_WIDTH) begin : g_c_drop
        logic [C_WIDTH-P_WIDTH-1:0] unused_c_hi;
        assign unused_c_hi = c_src[C_WIDTH-1:P_WIDTH];
      end
    end else begin : g_c_ext
      assign c_p = {{(P_WIDTH-C_WIDTH){1'b0}}, c_src};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // ALU / P stage. Feedback reads p_q, the result of the previous enabled edge.
  // This lets back-to-back accumulates chain without bubbles.
  // ---------------------------------------------------------------------------
  logic [P_WIDTH-1:0] p_q, p_d;
  logic               vld_q, vld_d;
  logic [P_WIDTH-1:0] z;

  always_comb begin
    z = '0;
    case (zsel_s)
      2'b01:   z = c_p;
      2'b10:   z = p_q;
      2'b11:   z = p_q >> SHIFT;
      default: z = '0;
    endcase
  end

  // P is updated on every enabled edge. Valid only qualifies the output strobe.
  always_comb begin
    p_d   = ce_i ? (m_p + z) : p_q;
    vld_d = ce_i ? vld_s : vld_q;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      p_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      vld_q <= vld_d;
    end
  end

  assign P_o     = p_q;
  assign valid_o = vld_q & ce_i;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Purpose: directed, table-driven check of dsp_mac_pipe (defaults) plus a LAT=1/CREG=0 instance.
// Latency: each row is one clock; the expected values are the outputs seen during that row's cycle.
// Backpressure: stall rows drive ce_i=0 and expect P_o held with valid_o low.
module tb_dsp_mac_pipe;

  logic        clk = 1'b1;
  logic        rst_n;
  logic        ce;
  logic        vld;
  logic [2:0]  mode;
  logic [16:0] a, b;
  logic        cen;
  logic [33:0] c;
  logic [33:0] p1, p2;
  logic        v1, v2;

  always #5 clk = ~clk;

  dsp_mac_pipe dut (
    .clock_i(clk), .reset_n_i(rst_n), .ce_i(ce), .valid_i(vld), .mode_i(mode),
    .A_i(a), .B_i(b), .CREG_en_i(cen), .C_i(c), .P_o(p1), .valid_o(v1)
  );

  dsp_mac_pipe #(.ABREG(0), .MREG(0), .CREG(0)) dut2 (
    .clock_i(clk), .reset_n_i(rst_n), .ce_i(ce), .valid_i(vld), .mode_i(mode),
    .A_i(a), .B_i(b), .CREG_en_i(cen), .C_i(c), .P_o(p2), .valid_o(v2)
  );

  typedef struct {
    logic        rst_n;
    logic        ce;
    logic        vld;
    logic [2:0]  mode;
    logic [16:0] a;
    logic [16:0] b;
    logic        cen;
    logic [33:0] c;
    logic        chk;
    logic [33:0] exp_p;
    logic        exp_v;
  } vec_t;

  localparam logic [16:0] MX = 17'h1FFFF;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n_f, input logic ce_f, input logic vld_f,
                              input logic [2:0] mode_f, input logic [16:0] a_f,
                              input logic [16:0] b_f, input logic cen_f, input logic [33:0] c_f,
                              input logic chk_f, input logic [33:0] ep, input logic ev);
    vec_t v;
    v.rst_n = rst_n_f; v.ce = ce_f; v.vld = vld_f; v.mode = mode_f;
    v.a = a_f; v.b = b_f; v.cen = cen_f; v.c = c_f;
    v.chk = chk_f; v.exp_p = ep; v.exp_v = ev;
    return v;
  endfunction

  function automatic vec_t idle(input logic [33:0] ep, input logic ev);
    return mk(1'b1, 1'b1, 1'b0, 3'b000, 17'd0, 17'd0, 1'b0, 34'd0, 1'b1, ep, ev);
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp_val);
    n_vec++;
    if (act !== exp_val) begin
      n_miss++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp_val);
    end
  endtask

  // Drive one row, compare at the falling edge, then step past the rising edge.
  task automatic apply(input vec_t v, input string tag, input bit use2);
    rst_n = v.rst_n; ce = v.ce; vld = v.vld; mode = v.mode;
    a = v.a; b = v.b; cen = v.cen; c = v.c;
    @(negedge clk);
    if (v.chk) begin
      check({tag, " P_o"}, use2 ? p2 : p1, v.exp_p);
      check({tag, " valid_o"}, {33'd0, use2 ? v2 : v1}, {33'd0, v.exp_v});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles with garbage valid operands; the C load must lose to reset.
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b000, MX, MX, 1'b1, 34'd5, 1'b0, 34'd0, 1'b0)); // 0
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'b000, MX, MX, 1'b1, 34'd5, 1'b1, 34'd0, 1'b0)); // 1
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 2
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 3
    // Basic 3*5: valid only in cycle +3.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b000, 17'd3, 17'd5, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0)); // 4
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 5
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 6
    vecs.push_back(idle(34'd15, 1'b1));                                                     // 7
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 8
    // Multiply + C (C loaded one cycle after issue), then a shift chain with no bubbles.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b001, MX, MX, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0));   // 9
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b111, MX, MX, 1'b1, 34'd1, 1'b1, 34'd0, 1'b0));   // 10
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b011, 17'd2, 17'd3, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0)); // 11
    vecs.push_back(idle(34'h3_FFFC_0002, 1'b1));                                            // 12
    vecs.push_back(idle(34'h0_0001_FFFE, 1'b1));                                            // 13
    vecs.push_back(idle(34'd6, 1'b1));                                                      // 14
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 15
    // Accumulate with wrap mod 2^34.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b000, MX, MX, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0));   // 16
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b010, MX, MX, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0));   // 17
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 18
    vecs.push_back(idle(34'h3_FFFC_0001, 1'b1));                                            // 19
    vecs.push_back(idle(34'h3_FFF8_0002, 1'b1));                                            // 20
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 21
    // Two-cycle stall after issue: the result arrives two cycles late.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b000, 17'd3, 17'd5, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0)); // 22
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, 17'd0, 17'd0, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0)); // 23
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, 17'd0, 17'd0, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0)); // 24
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 25
    // Issue 7*9, then reset while it is in flight and P=15; the C load must lose to reset.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b000, 17'd7, 17'd9, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0)); // 26
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 3'b000, 17'd0, 17'd0, 1'b1, 34'h100, 1'b1, 34'd15, 1'b1)); // 27
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 28
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 29
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 30
    // Multiply + C after reset: C was cleared, so only the product appears.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 3'b001, 17'd2, 17'd2, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0)); // 31
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 32
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 33
    vecs.push_back(idle(34'd4, 1'b1));                                                      // 34
    vecs.push_back(idle(34'd0, 1'b0));                                                      // 35

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("row%0d", i), 1'b0);
    end

    // Stall while a result is on P_o: P holds, valid_o is masked, and reset beats ce_i=0.
    apply(mk(1'b1, 1'b1, 1'b1, 3'b000, 17'd4, 17'd4, 1'b0, 34'd0, 1'b1, 34'd0, 1'b0), "hold0", 1'b0);
    apply(idle(34'd0, 1'b0), "hold1", 1'b0);
    apply(idle(34'd0, 1'b0), "hold2", 1'b0);
    apply(mk(1'b1, 1'b0, 1'b0, 3'b000, 17'd0, 17'd0, 1'b0, 34'd0, 1'b1, 34'd16, 1'b0), "hold3", 1'b0);
    apply(mk(1'b1, 1'b0, 1'b0, 3'b000, 17'd0, 17'd0, 1'b0, 34'd0, 1'b1, 34'd16, 1'b0), "hold4", 1'b0);
    apply(mk(1'b0, 1'b0, 1'b0, 3'b000, 17'd0, 17'd0, 1'b0, 34'd0, 1'b1, 34'd16, 1'b0), "hold5", 1'b0);
    apply(idle(34'd0, 1'b0), "hold6", 1'b0);

    // LAT=1 with an unregistered C: C_i is used in the issue cycle; accumulate and shift follow.
    apply(mk(1'b1, 1'b1, 1'b1, 3'b001, 17'd3, 17'd5, 1'b0, 34'd7, 1'b1, 34'd0, 1'b0), "lat1_0", 1'b1);
    apply(mk(1'b1, 1'b1, 1'b1, 3'b010, 17'd1, 17'd1, 1'b0, 34'd0, 1'b1, 34'd22, 1'b1), "lat1_1", 1'b1);
    apply(mk(1'b1, 1'b1, 1'b1, 3'b011, 17'd0, 17'd0, 1'b0, 34'd0, 1'b1, 34'd23, 1'b1), "lat1_2", 1'b1);
    apply(idle(34'd0, 1'b1), "lat1_3", 1'b1);
    apply(idle(34'd0, 1'b0), "lat1_4", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
